// File: rtl/tlb_l1_pkg.sv
// rtl/tlb_l1_pkg.sv - shared TLB entry type, match rule and PA composition
package tlb_l1_pkg;
  localparam int TLBNUM   = 16;
  localparam int TLBIDLEN = $clog2(TLBNUM);
  localparam logic [5:0] PS_4M = 6'd21;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] pa;
    logic        v;
    logic        d;
    logic [1:0]  plv;
    logic [1:0]  mat;
  } tlb_page_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_L2_WAIT} l1_state_t;

  // Large pages ignore the low vppn bits, which lie inside the page pair.
  function automatic logic tlb_match(input tlb_entry_t ent, input logic [18:0] vppn,
                                     input logic [9:0] asid);
    logic vppn_hit;
    vppn_hit = (ent.ps == PS_4M) ? (ent.vppn[18:9] == vppn[18:9]) : (ent.vppn == vppn);
    return ent.e && vppn_hit && (ent.g || (ent.asid == asid));
  endfunction

  function automatic tlb_page_t tlb_page(input tlb_entry_t ent, input logic [31:0] va);
    tlb_page_t  pg;
    logic       odd;
    logic [19:0] ppn;
    odd    = (ent.ps == PS_4M) ? va[21] : va[12];
    ppn    = odd ? ent.ppn1 : ent.ppn0;
    pg.v   = odd ? ent.v1 : ent.v0;
    pg.d   = odd ? ent.d1 : ent.d0;
    pg.plv = odd ? ent.plv1 : ent.plv0;
    pg.mat = odd ? ent.mat1 : ent.mat0;
    pg.pa  = (ent.ps == PS_4M) ? {ppn[19:9], va[20:0]} : {ppn, va[11:0]};
    return pg;
  endfunction
endpackage

// File: rtl/tlb_l1_if.sv
// rtl/tlb_l1_if.sv - lookup, response and L2 search port bundle for tlb_l1
interface tlb_l1_if;
  import tlb_l1_pkg::*;

  logic                lk_valid;
  logic                lk_ready;
  logic [31:0]         lk_va;
  logic [9:0]          lk_asid;
  logic                flush;
  logic                resp_valid;
  logic                resp_found;
  logic [31:0]         resp_pa;
  logic                resp_v;
  logic                resp_d;
  logic [1:0]          resp_plv;
  logic [1:0]          resp_mat;
  logic [TLBIDLEN-1:0] resp_index;
  logic [18:0]         l2_vppn;
  logic [9:0]          l2_asid;
  logic                l2_found;
  tlb_entry_t          l2_result;
  logic [TLBIDLEN-1:0] l2_index;

  modport slave (
    input  lk_valid, lk_va, lk_asid, flush, l2_found, l2_result, l2_index,
    output lk_ready, resp_valid, resp_found, resp_pa, resp_v, resp_d, resp_plv, resp_mat,
           resp_index, l2_vppn, l2_asid
  );

  modport master (
    output lk_valid, lk_va, lk_asid, flush, l2_found, l2_result, l2_index,
    input  lk_ready, resp_valid, resp_found, resp_pa, resp_v, resp_d, resp_plv, resp_mat,
           resp_index, l2_vppn, l2_asid
  );
endinterface

// File: rtl/tlb_l1_entry.sv
// rtl/tlb_l1_entry.sv - one L1 micro-TLB entry: storage plus match against the request key
module tlb_l1_entry
  import tlb_l1_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_flush,
  input  logic                i_we,
  input  tlb_entry_t          i_entry,
  input  logic [TLBIDLEN-1:0] i_index,
  input  logic [18:0]         i_vppn,
  input  logic [9:0]          i_asid,
  output logic                o_hit,
  output tlb_entry_t          o_entry,
  output logic [TLBIDLEN-1:0] o_index
);
  logic                r_valid;
  tlb_entry_t          r_entry;
  logic [TLBIDLEN-1:0] r_index;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_valid <= 1'b1;
    end
    if (i_we) begin
      r_entry <= i_entry;
      r_index <= i_index;
    end
  end

  assign o_hit   = r_valid && tlb_match(r_entry, i_vppn, i_asid);
  assign o_entry = r_entry;
  assign o_index = r_index;
endmodule

// File: rtl/tlb_l1.sv
// rtl/tlb_l1.sv - fully-associative L1 micro-TLB that searches the shared L2 TLB on a miss
module tlb_l1
  import tlb_l1_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input logic     clk,
  input logic     reset,
  tlb_l1_if.slave bus
);
  localparam int PTRW = $clog2(ENTRIES);

  l1_state_t           r_state;
  l1_state_t           w_next;
  logic [31:0]         r_va;
  logic [9:0]          r_asid;
  logic                r_found_q;
  logic [PTRW-1:0]     r_ptr;

  logic [ENTRIES-1:0]  w_hit_vec;
  tlb_entry_t          w_ent [ENTRIES];
  logic [TLBIDLEN-1:0] w_idx [ENTRIES];
  logic                w_l1_hit;
  tlb_entry_t          w_l1_ent;
  logic [TLBIDLEN-1:0] w_l1_idx;
  logic                w_ready;
  logic                w_valid;
  logic                w_found;
  logic                w_hs;
  logic                w_fill;
  tlb_entry_t          w_src_ent;
  logic [TLBIDLEN-1:0] w_src_idx;
  tlb_page_t           w_page;

  assign w_hs   = bus.lk_valid && w_ready;
  assign w_fill = (r_state == ST_L2_WAIT) && r_found_q && !bus.flush && !reset;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    tlb_l1_entry u_entry (
      .clk     (clk),
      .reset   (reset),
      .i_flush (bus.flush),
      .i_we    (w_fill && (r_ptr == PTRW'(g))),
      .i_entry (bus.l2_result),
      .i_index (bus.l2_index),
      .i_vppn  (r_va[31:13]),
      .i_asid  (r_asid),
      .o_hit   (w_hit_vec[g]),
      .o_entry (w_ent[g]),
      .o_index (w_idx[g])
    );
  end

  always_comb begin
    w_l1_hit = 1'b0;
    w_l1_ent = '0;
    w_l1_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_l1_hit = 1'b1;
        w_l1_ent = w_ent[i];
        w_l1_idx = w_idx[i];
      end
    end
  end

  // A flush while busy leaves the FSM in LOOKUP so the search reruns on the updated L2.
  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_valid   = 1'b0;
    w_found   = 1'b0;
    w_src_ent = w_l1_ent;
    w_src_idx = w_l1_idx;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.lk_valid) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (!bus.flush) begin
          if (w_l1_hit) begin
            w_valid = 1'b1;
            w_found = 1'b1;
            w_next  = ST_IDLE;
          end else begin
            w_next = ST_L2_WAIT;
          end
        end
      end
      ST_L2_WAIT: begin
        w_src_ent = bus.l2_result;
        w_src_idx = bus.l2_index;
        if (bus.flush) begin
          w_next = ST_LOOKUP;
        end else begin
          w_valid = 1'b1;
          w_found = r_found_q;
          w_next  = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (reset) begin
      w_ready = 1'b0;
      w_valid = 1'b0;
      w_found = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_found_q <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_LOOKUP) r_found_q <= bus.l2_found;
      if (w_fill) r_ptr <= r_ptr + 1'b1;
    end
    if (w_hs) begin
      r_va   <= bus.lk_va;
      r_asid <= bus.lk_asid;
    end
  end

  assign w_page         = tlb_page(w_src_ent, r_va);
  assign bus.lk_ready   = w_ready;
  assign bus.resp_valid = w_valid;
  assign bus.resp_found = w_found;
  assign bus.resp_pa    = w_found ? w_page.pa : '0;
  assign bus.resp_v     = w_found && w_page.v;
  assign bus.resp_d     = w_found && w_page.d;
  assign bus.resp_plv   = w_found ? w_page.plv : '0;
  assign bus.resp_mat   = w_found ? w_page.mat : '0;
  assign bus.resp_index = w_found ? w_src_idx : '0;
  assign bus.l2_vppn    = r_va[31:13];
  assign bus.l2_asid    = r_asid;
endmodule
